cronometro_core: RTL and testbench
==================================

# cronometro_core

Parametrised hardware stopwatch/countdown core that replaces the processor-driven stopwatch path. It counts MM:SS.CC (minutes, seconds, hundredths) in BCD directly in fabric, and drives six active-low 7-segment digits from the board switches. It adds a countdown mode with preset, a done indication, wrap reporting and an optional lap freeze. It sits between the board I/O (switches, displays) and the top-level wrapper.

## Interface
- CLK_HZ, 50_000_000, input clock frequency; hundredths divider DIV = CLK_HZ/100, must be ≥ 2
- SYNC_STAGES, 2, synchroniser depth on all switch inputs (≥ 2)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- mode  in  2  00 count up, 01 count down, 10/11 hold (counting inhibited)
- pause  in  1  level; 1 = paused, 0 = running
- clear  in  1  rising edge reloads the count
- lap  in  1  rising edge toggles lap view (only with lap feature)
- preset_min  in  7  countdown start minutes, binary, values > 59 clamp to 59
- preset_sec  in  7  countdown start seconds, binary, values > 59 clamp to 59
- disp0..disp5  out  7 each  segments {g,f,e,d,c,b,a}, active-low; disp0 = hundredths units … disp5 = minutes tens
- running  out  1  high while in RUN
- done  out  1  high in DONE (countdown reached 00:00.00)
- wrap  out  1  one-cycle pulse when up-count wraps 59:59.99 → 00:00.00

## Operation
- All switch inputs pass through SYNC_STAGES flops; clear and lap are then rising-edge detected (one-cycle pulses).
- Prescaler counts 0..DIV-1 and emits tick at DIV-1. It is held at 0 when not in RUN.
- Count: six BCD digits; CC 00–99, SS 00–59, MM 00–59. Up: carry CC→SS→MM. Down: borrow, with 00 → 99/59/59 on the lower fields.
- States: PAUSED, RUN, DONE.
  - PAUSED → RUN when synced pause = 0 and mode ∈ {00, 01}.
  - RUN → PAUSED when pause = 1 or mode ∈ {10, 11}.
  - RUN → DONE on a tick in mode 01 when the count is 00:00.00. The count stays at 00:00.00 and no decrement happens.
  - DONE → PAUSED only on clear or a change of synced mode.
- Clear pulse, or any change of synced mode, reloads the count: 00:00.00 if the new mode is up; {preset_min, preset_sec, 00} (clamped) if down. Hold mode leaves the count unchanged.
- Up wrap: 59:59.99 + tick → 00:00.00. wrap pulses and counting continues.
- Precedence in one cycle: reset > clear/mode-change reload > tick.
- Reload clears lap view and drops done the same cycle.
- Display: the segment encoder is registered. It shows the lap register when lap view is active, otherwise the live count. Non-BCD digit values show all segments off (7'h7F).

## Timing
- Reset values: count 00:00.00; state PAUSED; prescaler 0; disp0..disp5 = 7'b1000000 ("0"); running = 0, done = 0, wrap = 0; lap view off.
- Switch to effect: SYNC_STAGES + 1 cycles for an edge pulse, then the count or state updates on the next edge.
- Tick to count register: 1 cycle. Count to disp outputs: 1 further cycle.
- running and done are registered from the state (valid the cycle after a transition). wrap is aligned with the count register update.
- Reset deasserted mid-operation: outputs hold reset values until the first clk edge after release. No partial tick is carried over.

## Configuration
- CRONOMETRO_LAP_EN defined:
  - A lap pulse while in RUN copies the live count into the lap register and sets lap view.
  - A lap pulse while lap view is set clears it.
  - Counting continues underneath throughout.
  - A lap pulse outside RUN while lap view is off is ignored.
  - Clear and lap in the same cycle: clear wins and lap view ends off.
- CRONOMETRO_LAP_EN undefined: the lap input is unused, no lap register is built, and the display always shows the live count.

## Test plan
- CLK_HZ=1000 (DIV=10); reset low 3 cycles; mode=00, pause=0 → running=1, and after 100 ticks (1000 cycles) the count reads 00:01.00 and disp2 = 7'b1111001.
- Mode=00, count forced through 59:59.99 → next tick gives 00:00.00, wrap high exactly 1 cycle, counting continues.
- Mode=01, preset 0 min 2 s, clear → 00:02.00. Run 200 ticks → 00:00.00. Next tick → done=1, running=0, count frozen. Clear → done=0, count 00:02.00.
- preset_sec=75, mode=01, clear → loads 00:59.00. Pause=1 mid-run → prescaler held, count static for 500 cycles.
- LAP_EN: run to 00:03.27, lap → displays frozen at 03.27 while the internal count advances. Second lap → live count shown. Clear and lap same cycle → 00:00.00 with lap view off.
- Reset asserted mid-count at 00:45.12 → all outputs return to reset values immediately, asynchronously, without waiting for clk.

Source files
------------

// File: rtl/cronometro_core.sv
// rtl/cronometro_core.sv - BCD stopwatch/countdown core driving six 7-segment digits; lap freeze built only when CRONOMETRO_LAP_EN is defined
module cronometro_core #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       pause,
    input  logic       clear,
    input  logic       lap,
    input  logic [6:0] preset_min,
    input  logic [6:0] preset_sec,
    output logic [6:0] disp0,
    output logic [6:0] disp1,
    output logic [6:0] disp2,
    output logic [6:0] disp3,
    output logic [6:0] disp4,
    output logic [6:0] disp5,
    output logic       running,
    output logic       done,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / 100;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    // Per-digit maxima, digit 0 = hundredths units; also the 59:59.99 wrap point.
    localparam logic [23:0] DIGIT_MAX = 24'h595999;
    localparam logic [6:0]  SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_PAUSED = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Clamp a binary 0..127 switch value to 59 and split it into two BCD digits.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [6:0] c;
        c = (v > 7'd59) ? 7'd59 : v;
        return {4'(c / 7'd10), 4'(c % 7'd10)};
    endfunction

    // Increment with carry through CC -> SS -> MM; the top value rolls to zero.
    function automatic logic [5:0][3:0] bcd_inc(input logic [5:0][3:0] v);
        logic [5:0][3:0] r;
        logic [5:0][3:0] lim;
        logic            c;
        r   = v;
        lim = DIGIT_MAX;
        c   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (r[i] >= lim[i]) begin
                    r[i] = 4'd0;
                end else begin
                    r[i] = r[i] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Decrement with borrow; a zero digit reloads to its field maximum.
    function automatic logic [5:0][3:0] bcd_dec(input logic [5:0][3:0] v);
        logic [5:0][3:0] r;
        logic [5:0][3:0] lim;
        logic            b;
        r   = v;
        lim = DIGIT_MAX;
        b   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (r[i] == 4'd0) begin
                    r[i] = lim[i];
                end else begin
                    r[i] = r[i] - 4'd1;
                    b    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [SYNC_STAGES-1:0]      pause_sync_q;
    logic [SYNC_STAGES-1:0]      clear_sync_q;
    logic [SYNC_STAGES-1:0][1:0] mode_sync_q;
    logic [SYNC_STAGES-1:0][6:0] pmin_sync_q;
    logic [SYNC_STAGES-1:0][6:0] psec_sync_q;
    logic                        clear_prev_q;
    logic [1:0]                  mode_prev_q;

    logic                        pause_s;
    logic                        clear_s;
    logic [1:0]                  mode_s;
    logic                        clear_pulse;
    logic                        mode_chg;
    logic                        reload;
    logic [5:0][3:0]             preset_cnt;

    state_t                      state_q, state_d;
    logic [5:0][3:0]             cnt_q, cnt_d;
    logic [PW-1:0]               presc_q, presc_d;
    logic                        running_q;
    logic                        done_q;
    logic                        wrap_q, wrap_d;
    logic [5:0][3:0]             disp_src;
    logic [5:0][6:0]             disp_q;

    // Switch synchronisers; pause resets to 1 so the core stays paused until the real switch level arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pause_sync_q <= '1;
            clear_sync_q <= '0;
            mode_sync_q  <= '0;
            pmin_sync_q  <= '0;
            psec_sync_q  <= '0;
        end else begin
            pause_sync_q <= {pause_sync_q[SYNC_STAGES-2:0], pause};
            clear_sync_q <= {clear_sync_q[SYNC_STAGES-2:0], clear};
            mode_sync_q  <= {mode_sync_q[SYNC_STAGES-2:0], mode};
            pmin_sync_q  <= {pmin_sync_q[SYNC_STAGES-2:0], preset_min};
            psec_sync_q  <= {psec_sync_q[SYNC_STAGES-2:0], preset_sec};
        end
    end

    assign pause_s = pause_sync_q[SYNC_STAGES-1];
    assign clear_s = clear_sync_q[SYNC_STAGES-1];
    assign mode_s  = mode_sync_q[SYNC_STAGES-1];

    // Previous synced levels for clear edge and mode-change detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clear_prev_q <= 1'b0;
            mode_prev_q  <= 2'b00;
        end else begin
            clear_prev_q <= clear_s;
            mode_prev_q  <= mode_s;
        end
    end

    assign clear_pulse = clear_s & ~clear_prev_q;
    assign mode_chg    = (mode_s != mode_prev_q);
    assign reload      = clear_pulse | mode_chg;
    assign preset_cnt  = {to_bcd(pmin_sync_q[SYNC_STAGES-1]), to_bcd(psec_sync_q[SYNC_STAGES-1]), 8'h00};

    // Next state, prescaler and count: reload beats tick, and a run interrupted by pause restarts its prescaler.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        wrap_d  = 1'b0;
        if (reload) begin
            presc_d = '0;
            if (!mode_s[1]) begin
                cnt_d = mode_s[0] ? preset_cnt : '0;
            end
            if (state_q == ST_DONE) begin
                state_d = ST_PAUSED;
            end else if ((state_q == ST_RUN) && (pause_s || mode_s[1])) begin
                state_d = ST_PAUSED;
            end
        end else begin
            case (state_q)
                ST_PAUSED: begin
                    presc_d = '0;
                    if (!pause_s && !mode_s[1]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pause_s || mode_s[1]) begin
                        state_d = ST_PAUSED;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        if (mode_s[0]) begin
                            if (cnt_q == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                cnt_d = bcd_dec(cnt_q);
                            end
                        end else begin
                            cnt_d  = bcd_inc(cnt_q);
                            wrap_d = (cnt_q == DIGIT_MAX);
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    presc_d = '0;
                end
            endcase
        end
    end

    // State register with running/done/wrap registered alongside so they track the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PAUSED;
            cnt_q     <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            wrap_q    <= wrap_d;
        end
    end

`ifdef CRONOMETRO_LAP_EN
    logic [SYNC_STAGES-1:0] lap_sync_q;
    logic                   lap_prev_q;
    logic                   lap_pulse;
    logic                   lap_view_q, lap_view_d;
    logic [5:0][3:0]        lap_cnt_q, lap_cnt_d;

    // Lap switch synchroniser and edge history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_sync_q <= '0;
            lap_prev_q <= 1'b0;
        end else begin
            lap_sync_q <= {lap_sync_q[SYNC_STAGES-2:0], lap};
            lap_prev_q <= lap_sync_q[SYNC_STAGES-1];
        end
    end

    assign lap_pulse = lap_sync_q[SYNC_STAGES-1] & ~lap_prev_q;

    // Lap view toggling: reload always ends it, a pulse while shown hides it, a pulse in RUN captures the count.
    always_comb begin
        lap_view_d = lap_view_q;
        lap_cnt_d  = lap_cnt_q;
        if (reload) begin
            lap_view_d = 1'b0;
        end else if (lap_pulse) begin
            if (lap_view_q) begin
                lap_view_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                lap_view_d = 1'b1;
                lap_cnt_d  = cnt_q;
            end
        end
    end

    // Lap register and view flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_view_q <= 1'b0;
            lap_cnt_q  <= '0;
        end else begin
            lap_view_q <= lap_view_d;
            lap_cnt_q  <= lap_cnt_d;
        end
    end

    assign disp_src = lap_view_q ? lap_cnt_q : cnt_q;
`else
    logic lap_unused;
    assign lap_unused = lap;
    assign disp_src   = cnt_q;
`endif

    // Registered segment encoder for all six digits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q <= {6{SEG_ZERO}};
        end else begin
            for (int i = 0; i < 6; i++) begin
                disp_q[i] <= seg7(disp_src[i]);
            end
        end
    end

    assign disp0   = disp_q[0];
    assign disp1   = disp_q[1];
    assign disp2   = disp_q[2];
    assign disp3   = disp_q[3];
    assign disp4   = disp_q[4];
    assign disp5   = disp_q[5];
    assign running = running_q;
    assign done    = done_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_cronometro_core.sv
// tb/tb_cronometro_core.sv - scoreboard bench for cronometro_core against a hundredths-count reference model
module tb_cronometro_core;

    localparam int CLK_HZ = 1000;
    localparam int DIV    = CLK_HZ / 100;
    localparam int FULL   = 360000;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       pause, clear, lap;
    logic [6:0] preset_min, preset_sec;
    logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
    logic       running, done, wrap;

    cronometro_core #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .pause(pause), .clear(clear), .lap(lap),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3), .disp4(disp4), .disp5(disp5),
        .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk_disp;
        logic [41:0] disp;
        logic        running;
        logic        done;
        logic [7:0]  wraps;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  push_ev;
    int    vectors = 0;
    int    miscompares = 0;
    int    wrap_total = 0;
    int    wrap_base = 0;

    // Reference model: the count as plain hundredths 0..359999.
    int model_h = 0;
    bit model_done = 0;
    int model_wraps = 0;
    bit model_view = 0;
    int lap_h = 0;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] disp_of(input int h);
        int mm, ss, cc;
        mm = h / 6000;
        ss = (h / 100) % 60;
        cc = h % 100;
        return {seg(mm / 10), seg(mm % 10), seg(ss / 10), seg(ss % 10), seg(cc / 10), seg(cc % 10)};
    endfunction

    function automatic int preset_h();
        int m, s;
        m = (preset_min > 7'd59) ? 59 : int'(preset_min);
        s = (preset_sec > 7'd59) ? 59 : int'(preset_sec);
        return m * 6000 + s * 100;
    endfunction

    always @(negedge clk) if (wrap === 1'b1) wrap_total++;

    // Monitor: pops each pending expectation and compares it with the DUT outputs.
    initial begin
        exp_t        e;
        string       nm;
        logic [41:0] got;
        bit          bad;
        forever begin
            @(push_ev);
            #1;
            while (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {disp5, disp4, disp3, disp2, disp1, disp0};
                bad = 0;
                vectors++;
                if (e.chk_disp && (got !== e.disp)) begin
                    $display("FAIL %s: disp got %h want %h", nm, got, e.disp);
                    bad = 1;
                end
                if (running !== e.running) begin
                    $display("FAIL %s: running got %b want %b", nm, running, e.running);
                    bad = 1;
                end
                if (done !== e.done) begin
                    $display("FAIL %s: done got %b want %b", nm, done, e.done);
                    bad = 1;
                end
                if ((wrap_total - wrap_base) != int'(e.wraps)) begin
                    $display("FAIL %s: wrap cycles got %0d want %0d", nm, wrap_total - wrap_base, e.wraps);
                    bad = 1;
                end
                wrap_base = wrap_total;
                if (bad) miscompares++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors so far", vectors);
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input bit chk_disp, input bit run_exp);
        exp_t e;
        e.chk_disp  = chk_disp;
        e.disp      = disp_of(model_view ? lap_h : model_h);
        e.running   = run_exp;
        e.done      = model_done;
        e.wraps     = 8'(model_wraps);
        model_wraps = 0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        -> push_ev;
        #2;
    endtask

    task automatic reload();
        if (!mode[1]) model_h = mode[0] ? preset_h() : 0;
        model_done = 0;
        model_view = 0;
    endtask

    task automatic advance(input int k);
        if (mode == 2'b00) begin
            model_wraps += (model_h + k) / FULL;
            model_h = (model_h + k) % FULL;
        end else if (mode == 2'b01 && !model_done) begin
            if (k <= model_h) model_h -= k;
            else begin
                model_h    = 0;
                model_done = 1;
            end
        end
    endtask

    // Run for k prescaler periods plus half a period of margin, then pause and settle.
    task automatic run_ticks(input int k);
        pause = 1'b0;
        cyc(6);
        check("running", 0, (mode[1] == 1'b0) && !model_done);
        cyc(DIV * k + 5 - 6);
        pause = 1'b1;
        cyc(8);
        advance(k);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        cyc(6);
        clear = 1'b0;
        cyc(4);
        reload();
    endtask

    task automatic set_mode(input logic [1:0] m);
        if (m != mode) begin
            mode = m;
            cyc(8);
            reload();
        end
    endtask

    task automatic force_count(input logic [23:0] v, input int h);
        force dut.cnt_q = v;
        cyc(1);
        release dut.cnt_q;
        cyc(1);
        model_h = h;
    endtask

    initial begin
        int k;
        reset = 1'b0; mode = 2'b00; pause = 1'b1; clear = 1'b0; lap = 1'b0;
        preset_min = 7'd0; preset_sec = 7'd0;
        cyc(3);
        reset = 1'b1;
        check("reset_release", 1, 0);
        cyc(5);
        check("reset_idle", 1, 0);

        run_ticks(100);
        check("up_1s", 1, 0);
        repeat (3) begin
            k = $urandom_range(1, 60);
            run_ticks(k);
            check("up_rand", 1, 0);
        end

        force_count(24'h595999, 359999);
        check("pre_wrap", 1, 0);
        run_ticks(1);
        check("wrap", 1, 0);
        k = $urandom_range(1, 60);
        run_ticks(k);
        check("after_wrap", 1, 0);

        preset_sec = 7'd2;
        set_mode(2'b01);
        check("down_mode_load", 1, 0);
        pulse_clear();
        check("down_clear", 1, 0);
        run_ticks(200);
        check("down_zero", 1, 0);
        run_ticks(1);
        check("down_done", 1, 0);
        run_ticks(3);
        check("done_frozen", 1, 0);
        pulse_clear();
        check("done_clear", 1, 0);

        preset_sec = 7'd75;
        pulse_clear();
        check("clamp_load", 1, 0);
        k = $urandom_range(1, 100);
        run_ticks(k);
        check("clamp_run", 1, 0);
        cyc(500);
        check("pause_static", 1, 0);

        repeat (3) begin
            if ($urandom_range(0, 1) == 1) begin
                preset_min = 7'd0;
                preset_sec = 7'($urandom_range(0, 1));
            end else begin
                preset_min = 7'($urandom_range(0, 127));
                preset_sec = 7'($urandom_range(0, 127));
            end
            pulse_clear();
            check("cd_load", 1, 0);
            k = $urandom_range(1, 150);
            run_ticks(k);
            check("cd_run", 1, 0);
        end

        set_mode(2'b10);
        check("hold_enter", 1, 0);
        run_ticks(5);
        check("hold_static", 1, 0);
        set_mode(2'b00);
        check("up_reload", 1, 0);

`ifdef CRONOMETRO_LAP_EN
        run_ticks(327);
        check("lap_base", 1, 0);
        k = $urandom_range(10, 40);
        pause = 1'b0; cyc(4);
        lap = 1'b1; lap_h = model_h; model_view = 1; cyc(4);
        lap = 1'b0; cyc(20);
        check("lap_frozen", 1, 1);
        cyc(DIV * k + 5 - 28);
        pause = 1'b1; cyc(8);
        advance(k);
        check("lap_paused", 1, 0);
        lap = 1'b1; cyc(6); lap = 1'b0; cyc(4);
        model_view = 0;
        check("lap_live", 1, 0);
        lap = 1'b1; cyc(6); lap = 1'b0; cyc(4);
        check("lap_ignored", 1, 0);
        pause = 1'b0; cyc(4);
        lap = 1'b1; lap_h = model_h; model_view = 1; cyc(4);
        lap = 1'b0; cyc(DIV * k + 5 - 8);
        pause = 1'b1; cyc(8);
        advance(k);
        check("lap_again", 1, 0);
        clear = 1'b1; lap = 1'b1; cyc(6);
        clear = 1'b0; lap = 1'b0; cyc(4);
        reload();
        check("clear_lap", 1, 0);
`else
        k = $urandom_range(10, 40);
        pause = 1'b0; cyc(4);
        lap = 1'b1; cyc(4);
        lap = 1'b0; cyc(DIV * k + 5 - 8);
        pause = 1'b1; cyc(8);
        advance(k);
        check("lap_unused", 1, 0);
`endif

        force_count(24'h004512, 4512);
        check("pre_reset", 1, 0);
        pause = 1'b0;
        cyc(7);
        @(posedge clk);
        #2;
        reset = 1'b0;
        model_h = 0; model_done = 0; model_view = 0; model_wraps = 0;
        check("reset_async", 1, 0);
        pause = 1'b1;
        cyc(2);
        reset = 1'b1;
        check("reset_again", 1, 0);
        cyc(4);
        check("reset_after", 1, 0);

        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
